rotate_ctrl: RTL and testbench

ROTATE_CTRL -- requirements
Module: rotate_ctrl

---
 rtl/rotate_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rotate_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_ctrl.sv
// Rotation sequencer: edge-detects buttons, drives the rotator, then runs a collision-check handshake.
// Define ROTATE_CTRL_WALL_KICK_EN to allow one wall-kick retry per operation.
module rotate_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rot_r_i,
    input  logic       rot_l_i,
    input  logic       load_i,
    output logic [1:0] mode_o,
    output logic [3:0] par_o,
    input  logic       rot_done_i,
    input  logic [3:0] cand_i,
    output logic       chk_req_o,
    input  logic       chk_ack_i,
    input  logic       chk_ok_i,
    output logic [3:0] orient_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fail_o,
    output logic       kick_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ROT,
        CHECK,
        COMMIT,
        FAIL
`ifdef ROTATE_CTRL_WALL_KICK_EN
        , KICK
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] orient_q, orient_d;
    logic [3:0] cand_q, cand_d;
    logic       dir_q, dir_d;
    logic [3:0] wdog_q, wdog_d;
    logic       arm_q, arm_d;
    logic       prev_r_q, prev_l_q;
`ifdef ROTATE_CTRL_WALL_KICK_EN
    logic       kicked_q, kicked_d;
`endif

    logic rq_r, rq_l, req;

    assign rq_r = rot_r_i & ~prev_r_q;
    assign rq_l = rot_l_i & ~prev_l_q;
    assign req  = en & (rq_r ^ rq_l);

    assign orient_o = orient_q;
    assign par_o    = orient_q;

    always_comb begin
        state_d   = state_q;
        orient_d  = orient_q;
        cand_d    = cand_q;
        dir_d     = dir_q;
        wdog_d    = wdog_q;
        arm_d     = (state_q == WAIT_ROT);
`ifdef ROTATE_CTRL_WALL_KICK_EN
        kicked_d  = kicked_q;
`endif
        mode_o    = 2'b00;
        chk_req_o = 1'b0;
        busy_o    = (state_q != IDLE);
        done_o    = 1'b0;
        fail_o    = 1'b0;
        kick_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ISSUE;
                    dir_d   = rq_l;
`ifdef ROTATE_CTRL_WALL_KICK_EN
                    kicked_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                mode_o  = dir_q ? 2'b10 : 2'b01;
                wdog_d  = 4'd0;
                state_d = WAIT_ROT;
            end
            WAIT_ROT: begin
                // Entry cycle is not counted; timeout after 16 further cycles.
                if (rot_done_i) begin
                    cand_d  = cand_i;
                    state_d = CHECK;
                end else if (arm_q) begin
                    if (wdog_q == 4'hF) state_d = FAIL;
                    else                wdog_d  = wdog_q + 4'd1;
                end
            end
            CHECK: begin
                chk_req_o = 1'b1;
                if (chk_ack_i) begin
                    if (chk_ok_i) begin
                        orient_d = cand_q;
                        state_d  = COMMIT;
                    end else begin
`ifdef ROTATE_CTRL_WALL_KICK_EN
                        state_d = kicked_q ? FAIL : KICK;
`else
                        state_d = FAIL;
`endif
                    end
                end
            end
`ifdef ROTATE_CTRL_WALL_KICK_EN
            KICK: begin
                kick_o   = 1'b1;
                kicked_d = 1'b1;
                state_d  = CHECK;
            end
`endif
            COMMIT: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            FAIL: begin
                fail_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load_i) begin
            state_d  = IDLE;
            orient_d = 4'b0001;
            wdog_d   = 4'd0;
            arm_d    = 1'b0;
`ifdef ROTATE_CTRL_WALL_KICK_EN
            kicked_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            orient_q <= 4'b0001;
            cand_q   <= 4'b0001;
            dir_q    <= 1'b0;
            wdog_q   <= 4'd0;
            arm_q    <= 1'b0;
            prev_r_q <= 1'b0;
            prev_l_q <= 1'b0;
`ifdef ROTATE_CTRL_WALL_KICK_EN
            kicked_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            orient_q <= orient_d;
            cand_q   <= cand_d;
            dir_q    <= dir_d;
            wdog_q   <= wdog_d;
            arm_q    <= arm_d;
            prev_r_q <= rot_r_i;
            prev_l_q <= rot_l_i;
`ifdef ROTATE_CTRL_WALL_KICK_EN
            kicked_q <= kicked_d;
`endif
        end
    end

endmodule

// File: tb/tb_rotate_ctrl.sv
// Self-checking bench for rotate_ctrl with randomized rotator/checker responses.
// Honours ROTATE_CTRL_WALL_KICK_EN the same way the design does.
module tb_rotate_ctrl;

`ifdef ROTATE_CTRL_WALL_KICK_EN
    localparam bit KICK_EN = 1'b1;
`else
    localparam bit KICK_EN = 1'b0;
`endif

    logic       clk, rst, en, rot_r_i, rot_l_i, load_i;
    logic [1:0] mode_o;
    logic [3:0] par_o;
    logic       rot_done_i;
    logic [3:0] cand_i;
    logic       chk_req_o, chk_ack_i, chk_ok_i;
    logic [3:0] orient_o;
    logic       busy_o, done_o, fail_o, kick_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] m_orient;

    rotate_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .rot_r_i(rot_r_i), .rot_l_i(rot_l_i), .load_i(load_i),
        .mode_o(mode_o), .par_o(par_o),
        .rot_done_i(rot_done_i), .cand_i(cand_i),
        .chk_req_o(chk_req_o), .chk_ack_i(chk_ack_i), .chk_ok_i(chk_ok_i),
        .orient_o(orient_o), .busy_o(busy_o), .done_o(done_o),
        .fail_o(fail_o), .kick_o(kick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] onehot();
        logic [3:0] v;
        v = 4'b0001 << $urandom_range(0, 3);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        m_orient = 4'b0001;
        total++;
        if ({busy_o, done_o, fail_o, kick_o, chk_req_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy_o, done_o, fail_o, kick_o, chk_req_o});
        end
        total++;
        if (mode_o !== 2'b00) begin
            bad++; $display("FAIL reset_mode: got %b want 00", mode_o);
        end
        total++;
        if (orient_o !== 4'b0001 || par_o !== 4'b0001) begin
            bad++;
            $display("FAIL reset_orient: orient %b par %b want 0001", orient_o, par_o);
        end
        rst = 1'b0;
        tick();
    endtask

    // One full operation; the expected outcome follows the accept/kick/fail rules.
    task automatic do_op(input bit left, input logic [3:0] cand, input int rdly,
                         input int amax, input bit ok1, input bit ok2, input bit en_drop);
        int  natt;
        bit  ok, exp_done;
        int  adly;
        rot_l_i = left;
        rot_r_i = ~left;
        tick();
        rot_l_i = 1'b0;
        rot_r_i = 1'b0;
        if (en_drop) en = 1'b0;
        total++;
        if (mode_o !== (left ? 2'b10 : 2'b01) || par_o !== m_orient || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL issue: mode %b par %b busy %b want mode %b par %b busy 1",
                     mode_o, par_o, busy_o, left ? 2'b10 : 2'b01, m_orient);
        end
        tick();
        for (int i = 0; i < rdly; i++) begin
            total++;
            if (mode_o !== 2'b00 || busy_o !== 1'b1 || chk_req_o !== 1'b0) begin
                bad++;
                $display("FAIL wait_rot: mode %b busy %b req %b want 00 1 0",
                         mode_o, busy_o, chk_req_o);
            end
            tick();
        end
        rot_done_i = 1'b1;
        cand_i     = cand;
        tick();
        rot_done_i = 1'b0;
        cand_i     = 4'($urandom);
        natt = (KICK_EN && !ok1) ? 2 : 1;
        for (int a = 0; a < natt; a++) begin
            ok   = (a == 0) ? ok1 : ok2;
            adly = $urandom_range(0, amax);
            for (int j = 0; j < adly; j++) begin
                chk_ok_i = 1'($urandom);
                total++;
                if (chk_req_o !== 1'b1) begin
                    bad++; $display("FAIL chk_req_hold: got %b want 1", chk_req_o);
                end
                tick();
            end
            chk_ack_i = 1'b1;
            chk_ok_i  = ok;
            total++;
            if (chk_req_o !== 1'b1) begin
                bad++; $display("FAIL chk_req_ack: got %b want 1", chk_req_o);
            end
            tick();
            chk_ack_i = 1'b0;
            chk_ok_i  = 1'b0;
            if (a == 0 && natt == 2) begin
                total++;
                if (kick_o !== 1'b1 || busy_o !== 1'b1 || chk_req_o !== 1'b0) begin
                    bad++;
                    $display("FAIL kick: kick %b busy %b req %b want 1 1 0",
                             kick_o, busy_o, chk_req_o);
                end
                tick();
            end
        end
        exp_done = ok1 || (KICK_EN && ok2);
        if (exp_done) m_orient = cand;
        total++;
        if (done_o !== exp_done || fail_o !== !exp_done || kick_o !== 1'b0
            || orient_o !== m_orient) begin
            bad++;
            $display("FAIL outcome: done %b fail %b kick %b orient %b want %b %b 0 %b",
                     done_o, fail_o, kick_o, orient_o, exp_done, !exp_done, m_orient);
        end
        tick();
        en = 1'b1;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || fail_o !== 1'b0) begin
            bad++;
            $display("FAIL back_idle: busy %b done %b fail %b want 000", busy_o, done_o, fail_o);
        end
    endtask

    task automatic test_basic();
        do_op(1'b0, 4'b0010, 0, 0, 1'b1, 1'b1, 1'b0);
        total++;
        if (orient_o !== 4'b0010) begin
            bad++; $display("FAIL basic_orient: got %b want 0010", orient_o);
        end
    endtask

    task automatic test_kick();
        do_op(1'b1, onehot(), $urandom_range(0, 4), 2, 1'b0, 1'b1, 1'b0);
        do_op(1'b1, onehot(), $urandom_range(0, 4), 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_en_drop();
        do_op(1'b0, onehot(), 2, 1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++)
            do_op(1'($urandom), onehot(), $urandom_range(0, 10), 3,
                  1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_timeout();
        rot_r_i = 1'b1;
        tick();
        rot_r_i = 1'b0;
        tick();
        for (int k = 0; k <= 16; k++) begin
            total++;
            if (fail_o !== 1'b0 || busy_o !== 1'b1 || mode_o !== 2'b00) begin
                bad++;
                $display("FAIL timeout_wait[%0d]: fail %b busy %b mode %b want 0 1 00",
                         k, fail_o, busy_o, mode_o);
            end
            tick();
        end
        total++;
        if (fail_o !== 1'b1 || orient_o !== m_orient) begin
            bad++;
            $display("FAIL timeout_fail: fail %b orient %b want 1 %b", fail_o, orient_o, m_orient);
        end
        tick();
        total++;
        if (busy_o !== 1'b0 || fail_o !== 1'b0) begin
            bad++; $display("FAIL timeout_idle: busy %b fail %b want 0 0", busy_o, fail_o);
        end
    endtask

    task automatic quiet(input string nm, input int n);
        for (int k = 0; k < n; k++) begin
            total++;
            if (busy_o !== 1'b0 || mode_o !== 2'b00 || done_o !== 1'b0 || fail_o !== 1'b0
                || kick_o !== 1'b0 || orient_o !== m_orient) begin
                bad++;
                $display("FAIL %s[%0d]: busy %b mode %b d/f/k %b%b%b orient %b want 0 00 000 %b",
                         nm, k, busy_o, mode_o, done_o, fail_o, kick_o, orient_o, m_orient);
            end
            tick();
        end
    endtask

    task automatic test_drop();
        logic [3:0] c;
        rot_r_i = 1'b1;
        rot_l_i = 1'b1;
        tick();
        quiet("drop_both", 4);
        rot_r_i = 1'b0;
        rot_l_i = 1'b0;
        tick();
        en = 1'b0;
        rot_l_i = 1'b1;
        tick();
        quiet("drop_en0", 4);
        rot_l_i = 1'b0;
        en = 1'b1;
        tick();
        c = onehot();
        rot_r_i = 1'b1;
        tick();
        rot_r_i = 1'b0;
        rot_l_i = 1'b1;
        tick();
        rot_l_i = 1'b0;
        rot_r_i = 1'b1;
        rot_done_i = 1'b1;
        cand_i = c;
        tick();
        rot_done_i = 1'b0;
        chk_ack_i = 1'b1;
        chk_ok_i = 1'b1;
        tick();
        chk_ack_i = 1'b0;
        chk_ok_i = 1'b0;
        m_orient = c;
        total++;
        if (done_o !== 1'b1 || orient_o !== c) begin
            bad++; $display("FAIL drop_busy_op: done %b orient %b want 1 %b", done_o, orient_o, c);
        end
        tick();
        quiet("drop_busy", 5);
        rot_r_i = 1'b0;
        tick();
    endtask

    task automatic test_load();
        do_op(1'b0, 4'b0100, 1, 1, 1'b1, 1'b1, 1'b0);
        rot_r_i = 1'b1;
        tick();
        rot_r_i = 1'b0;
        tick();
        rot_done_i = 1'b1;
        cand_i = 4'b1000;
        tick();
        rot_done_i = 1'b0;
        total++;
        if (chk_req_o !== 1'b1 || orient_o !== 4'b0100) begin
            bad++;
            $display("FAIL load_pre: req %b orient %b want 1 0100", chk_req_o, orient_o);
        end
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        chk_ack_i = 1'b1;
        chk_ok_i = 1'b1;
        m_orient = 4'b0001;
        total++;
        if (chk_req_o !== 1'b0 || busy_o !== 1'b0 || orient_o !== 4'b0001) begin
            bad++;
            $display("FAIL load_idle: req %b busy %b orient %b want 0 0 0001",
                     chk_req_o, busy_o, orient_o);
        end
        quiet("load_after", 4);
        chk_ack_i = 1'b0;
        chk_ok_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_op(1'b1, 4'b1000, 0, 1, 1'b1, 1'b1, 1'b0);
        rot_l_i = 1'b1;
        tick();
        rot_l_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rot_done_i = 1'b1;
        cand_i = 4'b0010;
        m_orient = 4'b0001;
        quiet("reset_mid", 6);
        rot_done_i = 1'b0;
        do_op(1'b0, 4'b0100, 3, 2, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; rot_r_i = 1'b0; rot_l_i = 1'b0; load_i = 1'b0;
        rot_done_i = 1'b0; cand_i = 4'b0; chk_ack_i = 1'b0; chk_ok_i = 1'b0;
        m_orient = 4'b0001;
        tick();
        test_reset();
        test_basic();
        test_kick();
        test_en_drop();
        test_timeout();
        test_drop();
        test_load();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
